// File: rtl/servo_pkg.sv
// servo_pkg: shared constants for the Wishbone servo ramp block.
// Latency: n/a (constants only).
// Backpressure: n/a.
package servo_pkg;
    localparam int NUM_CH = 8;   // servo channels
    localparam int PW_W   = 12;  // pulse-width register width (us)
    localparam int US_W   = 16;  // frame microsecond counter width

    // Register word indices, i.e. wb_adr_i[6:2]
    localparam logic [4:0] REG_TARGET0  = 5'd0;   // 0x00..0x1C
    localparam logic [4:0] REG_CURRENT0 = 5'd8;   // 0x20..0x3C
    localparam logic [4:0] REG_CTRL     = 5'd16;  // 0x40
    localparam logic [4:0] REG_STATUS   = 5'd17;  // 0x44
    localparam logic [4:0] REG_FRAME    = 5'd18;  // 0x48

    // CTRL fields
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_IE_BIT   = 1;
    localparam int CTRL_STEP_LSB = 8;

    // STATUS fields (MOVING occupies [7:0])
    localparam int STATUS_BUSY_BIT = 8;
    localparam int STATUS_DONE_BIT = 16;

    // CTRL reset values
    localparam logic       CTRL_EN_RST   = 1'b0;
    localparam logic       CTRL_IE_RST   = 1'b0;
    localparam logic [7:0] CTRL_STEP_RST = 8'd10;
endpackage

// File: rtl/servo_channel.sv
// servo_channel: one servo's TARGET/CURRENT registers, write clamp, per-frame ramp and pulse comparator.
// Latency: servo is registered (1 cycle after us_cnt); CURRENT changes on the frame_end edge.
// Backpressure: none; writes are accepted whenever wr_en is high.
// Ports: clk/rst (async active-low), en, us_cnt, frame_end, step, wr_en/wr_dat, target/current, moving, servo.
module servo_channel
    import servo_pkg::*;
#(
    parameter int min_us    = 500,
    parameter int max_us    = 2500,
    parameter int center_us = 1500
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [US_W-1:0] us_cnt,
    input  logic            frame_end,
    input  logic [7:0]      step,
    input  logic            wr_en,
    input  logic [31:0]     wr_dat,
    output logic [PW_W-1:0] target,
    output logic [PW_W-1:0] current,
    output logic            moving,
    output logic            servo
);
    localparam logic [31:0]     MIN_32   = 32'(min_us);
    localparam logic [31:0]     MAX_32   = 32'(max_us);
    localparam logic [PW_W-1:0] CENTER_W = PW_W'(center_us);

    logic [PW_W-1:0]   wr_clamped;
    logic [PW_W-1:0]   ramp_next;
    logic signed [12:0] diff;
    logic signed [12:0] step_s;

    // Clamp uses the full 32-bit write value so huge values saturate high.
    always_comb begin
        wr_clamped = wr_dat[PW_W-1:0];
        if (wr_dat < MIN_32) begin
            wr_clamped = MIN_32[PW_W-1:0];
        end else if (wr_dat > MAX_32) begin
            wr_clamped = MAX_32[PW_W-1:0];
        end
    end

    assign diff   = $signed({1'b0, target}) - $signed({1'b0, current});
    assign step_s = $signed({5'b0, step});

    // Snap to target when within one step (or step is 0), so no overshoot is possible.
    always_comb begin
        ramp_next = target;
        if (step != 8'd0) begin
            if (diff > step_s) begin
                ramp_next = current + PW_W'(step);
            end else if (diff < -step_s) begin
                ramp_next = current - PW_W'(step);
            end
        end
    end

    assign moving = (current != target);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            target  <= CENTER_W;
            current <= CENTER_W;
            servo   <= 1'b0;
        end else begin
            if (wr_en) begin
                target <= wr_clamped;
            end
            // The ramp reads the pre-edge target, so a same-cycle write lands next frame.
            if (frame_end) begin
                current <= ramp_next;
            end
            servo <= en && (us_cnt < US_W'(current));
        end
    end
endmodule

// File: rtl/wb_servo_ramp.sv
// wb_servo_ramp: Wishbone slave driving eight 50 Hz servo pulse trains that ramp toward CPU targets.
// Latency: ack/read data 1 cycle after cyc&stb; servo lags us_cnt by 1; DONE/irq 1 cycle after CURRENT settles.
// Backpressure: none; each request is acked in one cycle, a held strobe acks every other cycle.
// Ports: clk, rst (async active-low), wb_* slave (word access, adr[6:2] decoded), irq (level), servo[7:0].
module wb_servo_ramp
    import servo_pkg::*;
#(
    parameter int clk_freq  = 100000000,
    parameter int frame_us  = 20000,
    parameter int min_us    = 500,
    parameter int max_us    = 2500,
    parameter int center_us = 1500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic        irq,
    output logic [7:0]  servo
);
    localparam int              TICK_DIV   = clk_freq / 1000000;
    localparam logic [31:0]     PRESC_LAST = 32'(TICK_DIV - 1);
    localparam logic [US_W-1:0] US_LAST    = US_W'(frame_us - 1);

    logic [31:0]     presc;
    logic [US_W-1:0] us_cnt;
    logic            tick;
    logic            frame_end;
    logic            ctrl_en;
    logic            ctrl_ie;
    logic [7:0]      ctrl_step;
    logic            done;
    logic            busy;
    logic            busy_q;
    logic            done_clr;
    logic [7:0]      moving;
    logic [PW_W-1:0] tgt_a [NUM_CH];
    logic [PW_W-1:0] cur_a [NUM_CH];
    logic            req;
    logic            wr;
    logic [4:0]      widx;
    logic [31:0]     rd_mux;
    logic            unused_bits;

    assign unused_bits = ^{wb_sel_i, wb_adr_i[31:7], wb_adr_i[1:0]};

    // Time base: prescaler -> 1 us tick -> frame counter, all frozen at 0 while disabled.
    assign tick      = ctrl_en && (presc == PRESC_LAST);
    assign frame_end = tick && (us_cnt == US_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc  <= '0;
            us_cnt <= '0;
        end else if (!ctrl_en) begin
            presc  <= '0;
            us_cnt <= '0;
        end else begin
            presc <= (presc == PRESC_LAST) ? '0 : presc + 32'd1;
            if (frame_end) begin
                us_cnt <= '0;
            end else if (tick) begin
                us_cnt <= us_cnt + US_W'(1);
            end
        end
    end

    // A request is taken only when ack is low, which gives the every-other-cycle ack on a held strobe.
    assign req  = wb_cyc_i && wb_stb_i && !wb_ack_o;
    assign wr   = req && wb_we_i;
    assign widx = wb_adr_i[6:2];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        servo_channel #(
            .min_us   (min_us),
            .max_us   (max_us),
            .center_us(center_us)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (ctrl_en),
            .us_cnt   (us_cnt),
            .frame_end(frame_end),
            .step     (ctrl_step),
            .wr_en    (wr && (widx == REG_TARGET0 + 5'(k))),
            .wr_dat   (wb_dat_i),
            .target   (tgt_a[k]),
            .current  (cur_a[k]),
            .moving   (moving[k]),
            .servo    (servo[k])
        );
    end

    assign busy     = |moving;
    assign done_clr = wr && (widx == REG_STATUS) && wb_dat_i[STATUS_DONE_BIT];
    assign irq      = done && ctrl_ie;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_en   <= CTRL_EN_RST;
            ctrl_ie   <= CTRL_IE_RST;
            ctrl_step <= CTRL_STEP_RST;
            busy_q    <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (wr && (widx == REG_CTRL)) begin
                ctrl_en   <= wb_dat_i[CTRL_EN_BIT];
                ctrl_ie   <= wb_dat_i[CTRL_IE_BIT];
                ctrl_step <= wb_dat_i[CTRL_STEP_LSB +: 8];
            end
            busy_q <= busy;
            // Set has priority over a same-cycle clear.
            if (busy_q && !busy) begin
                done <= 1'b1;
            end else if (done_clr) begin
                done <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        if (widx < REG_CURRENT0) begin
            rd_mux = 32'(tgt_a[widx[2:0]]);
        end else if (widx < REG_CTRL) begin
            rd_mux = 32'(cur_a[widx[2:0]]);
        end else begin
            case (widx)
                REG_CTRL: begin
                    rd_mux[CTRL_EN_BIT]              = ctrl_en;
                    rd_mux[CTRL_IE_BIT]              = ctrl_ie;
                    rd_mux[CTRL_STEP_LSB +: 8]       = ctrl_step;
                end
                REG_STATUS: begin
                    rd_mux[7:0]             = moving;
                    rd_mux[STATUS_BUSY_BIT] = busy;
                    rd_mux[STATUS_DONE_BIT] = done;
                end
                REG_FRAME: rd_mux = 32'(us_cnt);
                default:   rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= req;
            wb_dat_o <= (req && !wb_we_i) ? rd_mux : '0;
        end
    end
endmodule

// File: tb/tb_wb_servo_ramp.sv
// tb_wb_servo_ramp: directed bench with a per-cycle behavioural model of the servo ramp block.
// Latency: n/a.
// Backpressure: n/a.
module tb_wb_servo_ramp;
    localparam int FRAME = 3000;

    logic        clk;
    logic        rst;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_ack_o;
    logic        irq;
    logic [7:0]  servo;

    int total = 0;
    int bad   = 0;

    wb_servo_ramp #(
        .clk_freq (1000000),
        .frame_us (FRAME),
        .min_us   (500),
        .max_us   (2500),
        .center_us(1500)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wb_adr_i(wb_adr_i),
        .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o),
        .wb_sel_i(wb_sel_i),
        .wb_we_i (wb_we_i),
        .wb_cyc_i(wb_cyc_i),
        .wb_stb_i(wb_stb_i),
        .wb_ack_o(wb_ack_o),
        .irq     (irq),
        .servo   (servo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // State is what the register map describes; one call per clock edge.
    int         m_tgt [8];
    int         m_cur [8];
    int         m_en, m_ie, m_step, m_done, m_busy_prev, m_us, m_ack;
    logic [31:0] m_dat;
    logic [7:0]  m_servo;

    function automatic int clamp(input logic [31:0] v);
        if (v < 32'd500) return 500;
        if (v > 32'd2500) return 2500;
        return int'(v);
    endfunction

    function automatic int ramp(input int cur, input int tgt, input int stp);
        int d = tgt - cur;
        int ad = (d < 0) ? -d : d;
        if (stp == 0 || ad <= stp) return tgt;
        return (d > 0) ? cur + stp : cur - stp;
    endfunction

    function automatic int any_moving();
        for (int k = 0; k < 8; k++) if (m_cur[k] != m_tgt[k]) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] model_reg(input int idx);
        int mv = 0;
        if (idx < 8) return 32'(m_tgt[idx]);
        if (idx < 16) return 32'(m_cur[idx - 8]);
        if (idx == 16) return 32'(m_step * 256 + m_ie * 2 + m_en);
        if (idx == 17) begin
            for (int k = 0; k < 8; k++) if (m_cur[k] != m_tgt[k]) mv += (1 << k);
            return 32'(mv + ((mv != 0) ? 256 : 0) + m_done * 65536);
        end
        if (idx == 18) return 32'(m_us);
        return 32'd0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            m_tgt[k] = 1500;
            m_cur[k] = 1500;
        end
        m_en = 0; m_ie = 0; m_step = 10; m_done = 0; m_busy_prev = 0;
        m_us = 0; m_ack = 0; m_dat = 0; m_servo = 0;
    endtask

    task automatic model_step();
        int idx;
        int req, wr, fe, busy_now, settle;
        int nc [8];
        idx = int'(wb_adr_i[6:2]);
        req = (wb_cyc_i && wb_stb_i && m_ack == 0) ? 1 : 0;
        wr  = (req == 1 && wb_we_i) ? 1 : 0;
        // outputs for the coming cycle, from the state before this edge
        for (int k = 0; k < 8; k++) m_servo[k] = (m_en == 1 && m_us < m_cur[k]);
        m_dat = (req == 1 && !wb_we_i) ? model_reg(idx) : 32'd0;
        m_ack = req;
        fe = (m_en == 1 && m_us == FRAME - 1) ? 1 : 0;
        for (int k = 0; k < 8; k++) nc[k] = (fe == 1) ? ramp(m_cur[k], m_tgt[k], m_step) : m_cur[k];
        // DONE: channels were busy one edge ago and are idle now
        busy_now = any_moving();
        settle = (m_busy_prev == 1 && busy_now == 0) ? 1 : 0;
        m_busy_prev = busy_now;
        if (settle == 1) m_done = 1;
        else if (wr == 1 && idx == 17 && wb_dat_i[16]) m_done = 0;
        m_us = (m_en == 0 || fe == 1) ? 0 : m_us + 1;
        if (wr == 1 && idx < 8) m_tgt[idx] = clamp(wb_dat_i);
        if (wr == 1 && idx == 16) begin
            m_en = int'(wb_dat_i[0]);
            m_ie = int'(wb_dat_i[1]);
            m_step = int'(wb_dat_i[15:8]);
        end
        for (int k = 0; k < 8; k++) m_cur[k] = nc[k];
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    // per-cycle comparison of every output against the model
    initial begin
        #2;
        forever begin
            @(negedge clk);
            chk("cyc_ack", 32'(wb_ack_o), 32'(m_ack));
            chk("cyc_dat", wb_dat_o, m_dat);
            chk("cyc_servo", 32'(servo), 32'(m_servo));
            chk("cyc_irq", 32'(irq), 32'(m_done * m_ie));
        end
    end

    // ---------------- bus and sync helpers ----------------
    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        wb_adr_i = a; wb_dat_i = d; wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        do begin @(negedge clk); n++; end while (wb_ack_o !== 1'b1 && n < 8);
        chk("wr_ack", 32'(wb_ack_o), 32'd1);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        int n = 0;
        @(negedge clk);
        wb_adr_i = a; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        do begin @(negedge clk); n++; end while (wb_ack_o !== 1'b1 && n < 8);
        chk("rd_ack", 32'(wb_ack_o), 32'd1);
        d = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    endtask

    // Returns at the first negedge where servo[0] is high after being low (start of a frame).
    task automatic wait_rise();
        int n = 0;
        while (servo[0] !== 1'b0 && n < 4000) begin @(negedge clk); n++; end
        while (servo[0] !== 1'b1 && n < 8000) begin @(negedge clk); n++; end
        chk("rise_seen", 32'(servo[0]), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] rd;
        int hi, lo;
        rst = 1'b1;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = 4'hF;
        wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // reset state
        chk("reset_servo", 32'(servo), 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);
        wb_read(32'h00, rd); chk("reset_target0", rd, 32'd1500);
        wb_read(32'h40, rd); chk("reset_ctrl", rd, 32'h00000A00);
        wb_read(32'h44, rd); chk("reset_status", rd, 32'd0);
        wb_read(32'h4C, rd); chk("unmapped_read", rd, 32'd0);

        // enable: 1500 high / 1500 low
        wb_write(32'h40, 32'h00000A01);
        wait_rise();
        chk("all_high", 32'(servo), 32'hFF);
        hi = 0;
        while (servo[0] === 1'b1 && hi < 4000) begin hi++; @(negedge clk); end
        lo = 0;
        while (servo[0] === 1'b0 && lo < 4000) begin lo++; @(negedge clk); end
        chk("pulse_high", 32'(hi), 32'd1500);
        chk("pulse_low", 32'(lo), 32'd1500);

        // ramp channel 3 at STEP=100 with interrupt enabled
        wb_write(32'h40, 32'h00006403);
        wb_write(32'h0C, 32'd1800);
        wait_rise();
        wb_read(32'h2C, rd); chk("cur3_f1", rd, 32'd1600);
        wb_read(32'h44, rd); chk("status_moving3", rd, 32'h00000108);
        wait_rise();
        wb_read(32'h2C, rd); chk("cur3_f2", rd, 32'd1700);
        wait_rise();
        wb_read(32'h2C, rd); chk("cur3_f3", rd, 32'd1800);
        wb_read(32'h44, rd); chk("status_done", rd, 32'h00010000);
        chk("irq_set", 32'(irq), 32'd1);
        wb_write(32'h44, 32'h00010000);
        chk("irq_cleared", 32'(irq), 32'd0);

        // clamping on channel 5
        wb_write(32'h14, 32'd4000);
        wb_read(32'h14, rd); chk("clamp_hi", rd, 32'd2500);
        wb_write(32'h14, 32'd10);
        wb_read(32'h14, rd); chk("clamp_lo", rd, 32'd500);
        wb_write(32'h14, 32'd1500);
        wb_write(32'h44, 32'h00010000);

        // STEP=0 jumps in one frame
        wb_write(32'h40, 32'h00000003);
        wb_write(32'h04, 32'd600);
        wait_rise();
        wb_read(32'h24, rd); chk("step0_cur1", rd, 32'd600);

        // target write landing exactly on frame_end uses the old target
        wait_rise();
        repeat (2997) @(negedge clk);
        wb_write(32'h04, 32'd900);
        wait_rise();
        wb_read(32'h24, rd); chk("fe_write_old", rd, 32'd600);
        wait_rise();
        wb_read(32'h24, rd); chk("fe_write_new", rd, 32'd900);

        // asynchronous reset in the middle of a ramp
        wb_write(32'h40, 32'h00006403);
        wb_write(32'h08, 32'd2500);
        wait_rise();
        repeat (700) @(negedge clk);
        chk("pre_rst_irq", 32'(irq), 32'd1);
        chk("pre_rst_servo", 32'(servo), 32'hFF);
        #2 rst = 1'b0;
        #1;
        chk("rst_servo", 32'(servo), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_ack", 32'(wb_ack_o), 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        wb_read(32'h28, rd); chk("rst_cur2", rd, 32'd1500);
        wb_read(32'h08, rd); chk("rst_tgt2", rd, 32'd1500);
        wb_read(32'h40, rd); chk("rst_ctrl", rd, 32'h00000A00);
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
